// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output channels of the RV32 instruction encoder.
// The encoder connects through the slave modport; the producer/consumer side uses master.
interface instr_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, last, out_ready,
    input  in_ready, out_valid, out_word, out_addr
  );

  modport slave (
    input  in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, last, out_ready,
    output in_ready, out_valid, out_word, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV32 instruction encoder: field bundles in, 32-bit words with addresses out.
// Optional macro IMM_CHECK_EN adds immediate range checking to err_o.
module instr_encoder #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  instr_encoder_if.slave    bus,
  output logic              done_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              err_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              start_go, accept, out_hs;
  logic [31:0]       enc_word;
  logic              enc_illegal, imm_bad;
  logic signed [31:0] imm_s;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and a raised out_valid holds word/addr until taken.
  assign start_go = (state_q == S_IDLE) && start_i;
  assign bus.in_ready = (state_q == S_ACTIVE) && (!valid_q || bus.out_ready);
  assign accept   = bus.in_valid && bus.in_ready;
  assign out_hs   = valid_q && bus.out_ready;
  assign imm_s    = bus.imm;

  always_comb begin
    enc_word    = 32'h0000_0013;
    enc_illegal = 1'b0;
    case (bus.fmt)
      3'd0: enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0110011};
      3'd1: enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
      3'd2: enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0000011};
      3'd3: enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], 7'b0100011};
      3'd4: enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                        bus.imm[4:1], bus.imm[11], 7'b1100011};
      default: enc_illegal = 1'b1;
    endcase
  end

`ifdef IMM_CHECK_EN
  always_comb begin
    imm_bad = 1'b0;
    case (bus.fmt)
      3'd1, 3'd2, 3'd3: imm_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      3'd4:             imm_bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || bus.imm[0];
      default:          imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
  logic unused_imm;
  assign unused_imm = ^imm_s;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_ACTIVE;
      S_ACTIVE: if (accept && bus.last) state_d = S_DRAIN;
      S_DRAIN:  if (out_hs) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    word_d  = word_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    done_d  = out_hs && last_q;
    if (start_go) begin
      addr_d  = base_addr_i;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (out_hs) begin
        addr_d  = addr_q + ADDR_W'(4);
        count_d = count_q + CNT_W'(1);
      end
      if (accept && (enc_illegal || imm_bad)) err_d = 1'b1;
    end
    // A same-edge handshake and accept simply replaces the word: full throughput.
    if (accept) begin
      valid_d = 1'b1;
      last_d  = bus.last;
      word_d  = enc_word;
    end else if (out_hs) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      word_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_word  = word_q;
  assign bus.out_addr  = addr_q;
  assign done_o        = done_q;
  assign count_o       = count_q;
  assign err_o         = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: scoreboard of expected {last, addr, word} entries.
module tb_instr_encoder;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;
  localparam int W      = 1 + ADDR_W + 32;

`ifdef IMM_CHECK_EN
  localparam logic RANGE_ERR = 1'b1;
`else
  localparam logic RANGE_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic              done_o;
  logic [CNT_W-1:0]  count_o;
  logic              err_o;
  logic [1:0]        state_o;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .bus         (bus),
    .done_o      (done_o),
    .count_o     (count_o),
    .err_o       (err_o),
    .state_o     (state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int hs_log[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  logic done_pend = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed timeout expected completion", tag);
  endtask

  function automatic logic [31:0] model_enc(input logic [31:0] fmt, input logic [31:0] rd,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] f3,
      input logic [31:0] f7, input logic [31:0] imm);
    logic [31:0] regs;
    regs = (rs1 << 15) | (f3 << 12);
    case (fmt)
      0: return (f7 << 25) | (rs2 << 20) | regs | (rd << 7) | 32'h33;
      1: return ((imm & 32'hfff) << 20) | regs | (rd << 7) | 32'h13;
      2: return ((imm & 32'hfff) << 20) | regs | (rd << 7) | 32'h03;
      3: return (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | regs | ((imm & 32'h1f) << 7) | 32'h23;
      4: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (rs2 << 20) | regs
                | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      default: return 32'h13;
    endcase
  endfunction

  // scoreboard monitor: done check uses the handshake seen one cycle earlier
  always @(negedge clk) begin
    logic [W-1:0] e;
    chk("done_o", done_o, done_pend);
    done_pend = 1'b0;
    if (rst_i && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", bus.out_word, 32'hx);
      end else begin
        e = exp_q.pop_front();
        chk("out_word", bus.out_word, e[31:0]);
        chk("out_addr", bus.out_addr, e[63:32]);
        done_pend = e[64];
        hs_log.push_back(cyc);
      end
    end
  end

  // driver tasks: called and returning at posedge+1
  task automatic start_stream(input logic [ADDR_W-1:0] base);
    start_i = 1'b1;
    base_addr_i = base;
    @(posedge clk); #1;
    start_i = 1'b0;
    exp_addr = base;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, input logic last, input logic [31:0] exp_word);
    logic got;
    bus.fmt = fmt; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
    bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm; bus.last = last;
    bus.in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) got = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (got) begin
      exp_q.push_back({last, exp_addr, exp_word});
      exp_addr = exp_addr + 32'd4;
    end else begin
      timeout_fail("send_accept");
    end
  endtask

  task automatic drain(input int words);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      timeout_fail("drain");
      exp_q.delete();
    end
    @(posedge clk); #1;
    chk("count_o", count_o, words);
    chk("state_idle", state_o, 2'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.last = 1'b0;
    bus.fmt = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_word", bus.out_word, 32'h0);
    chk("rst_addr", bus.out_addr, 32'h0);
    chk("rst_count", count_o, 16'h0);
    chk("rst_state", state_o, 2'd0);
    rst_i = 1'b1;
    @(posedge clk); #1;

    // 1: single R word
    start_stream(32'h100);
    chk("active_state", state_o, 2'd1);
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3);
    drain(1);

    // 2: I then SW (last)
    start_stream(32'h0);
    chk("start_clears_count", count_o, 16'h0);
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h00500093);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'h0020A423);
    drain(2);
    chk("err_clean", err_o, 1'b0);

    // 3: BEQ stalled 3 cycles, start ignored while active
    start_stream(32'h200);
    bus.out_ready = 1'b0;
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'hFE208EE3);
    bus.fmt = 3'd0; bus.in_valid = 1'b1;
    start_i = 1'b1; base_addr_i = 32'h9000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.out_valid, 1'b1);
      chk("stall_word", bus.out_word, 32'hFE208EE3);
      chk("stall_addr", bus.out_addr, 32'h200);
      chk("stall_in_ready", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    bus.out_ready = 1'b1;
    send(3'd0, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'd0, 1'b1, 32'h407302B3);
    drain(2);

    // 4: eight back-to-back random bundles
    start_stream(32'h1000);
    hs_log.delete();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] f; logic [4:0] a, b, c; logic [2:0] f3; logic [6:0] f7; logic [31:0] im;
      f = 3'($urandom_range(0, 4));
      a = 5'($urandom_range(0, 31)); b = 5'($urandom_range(0, 31)); c = 5'($urandom_range(0, 31));
      f3 = 3'($urandom_range(0, 7)); f7 = 7'($urandom_range(0, 127));
      im = $urandom;
      send(f, a, b, c, f3, f7, im, (i == 7), model_enc(32'(f), 32'(a), 32'(b), 32'(c),
           32'(f3), 32'(f7), im));
    end
    drain(8);
    if (hs_log.size() == 8) begin
      for (int i = 1; i < 8; i++) chk("b2b_consecutive", hs_log[i] - hs_log[i-1], 1);
    end else begin
      chk("b2b_hs_count", hs_log.size(), 8);
    end

    // 5: range check and illegal format
    start_stream(32'h0);
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 32'h80000093);
    chk("err_imm_i", err_o, RANGE_ERR);
    drain(1);
    start_stream(32'h40);
    chk("err_cleared_on_start", err_o, 1'b0);
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b1, 32'h00208163);
    chk("err_imm_beq", err_o, RANGE_ERR);
    drain(1);
    start_stream(32'h80);
    send(3'd6, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 32'd0, 1'b1, 32'h00000013);
    chk("err_illegal", err_o, 1'b1);
    drain(1);

    // 6: reset during a stalled word
    start_stream(32'h300);
    bus.out_ready = 1'b0;
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'h002081B3);
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    rst_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    exp_q.delete();
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_word", bus.out_word, 32'h0);
    chk("mid_rst_addr", bus.out_addr, 32'h0);
    chk("mid_rst_count", count_o, 16'h0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b0);
    chk("mid_rst_state", state_o, 2'd0);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_valid", bus.out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
